// File: rtl/word_to_byte_unpacker.sv
// Width-down converter: takes one NBits word and emits its bytes LSB-first over a
// valid/ready byte stream. Narrow words emit only byte 0.
module word_to_byte_unpacker #(
    parameter int NBits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [NBits-1:0] in_data,
    input  logic             in_narrow,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int NBytes = NBits / 8;
    localparam int CntW   = $clog2(NBytes) + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state, state_nxt;
    logic [NBits-1:0]  shift;
    logic [CntW-1:0]   remaining;
    logic              load;
    logic              out_hs;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_data  = shift[7:0];
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (remaining == CntW'(1));
                // Accepting on the final byte handshake removes the bubble between words.
                in_ready  = out_last && out_ready;
                if (out_last && out_ready && !in_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load   = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shift     <= in_data;
                remaining <= in_narrow ? CntW'(1) : CntW'(NBytes);
            end else if (out_hs && (remaining > CntW'(1))) begin
                shift     <= shift >> 8;
                remaining <= remaining - CntW'(1);
            end else if (out_hs) begin
                remaining <= '0;
            end
        end
    end

endmodule

// File: tb/tb_word_to_byte_unpacker.sv
// Self-checking bench for word_to_byte_unpacker: 16-bit and 32-bit instances,
// expected bytes queued on input acceptance and compared as bytes are taken.
module tb_word_to_byte_unpacker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid16, in_narrow16, in_ready16;
    logic [15:0] in_data16;
    logic        out_valid16, out_last16, out_ready16, busy16;
    logic [7:0]  out_data16;

    logic        in_valid32, in_narrow32, in_ready32;
    logic [31:0] in_data32;
    logic        out_valid32, out_last32, out_ready32, busy32;
    logic [7:0]  out_data32;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q16[$];
    logic [8:0] q32[$];

    word_to_byte_unpacker #(.NBits(16)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_data(in_data16), .in_narrow(in_narrow16),
        .in_ready(in_ready16), .out_valid(out_valid16), .out_data(out_data16),
        .out_last(out_last16), .out_ready(out_ready16), .busy(busy16)
    );

    word_to_byte_unpacker #(.NBits(32)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_data(in_data32), .in_narrow(in_narrow32),
        .in_ready(in_ready32), .out_valid(out_valid32), .out_data(out_data32),
        .out_last(out_last32), .out_ready(out_ready32), .busy(busy32)
    );

    // Inputs only change #1 after posedge, so a negedge sample predicts the next edge.
    always @(negedge clk) begin
        if (reset && out_valid16 && out_ready16) begin
            n_checks++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL sb16_unexpected: got byte %h last %b, required no byte", out_data16, out_last16);
            end else begin
                logic [8:0] e;
                e = q16.pop_front();
                if ({out_last16, out_data16} !== e) begin
                    n_fail++;
                    $display("FAIL sb16_byte: got byte %h last %b, required byte %h last %b",
                             out_data16, out_last16, e[7:0], e[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid32 && out_ready32) begin
            n_checks++;
            if (q32.size() == 0) begin
                n_fail++;
                $display("FAIL sb32_unexpected: got byte %h last %b, required no byte", out_data32, out_last32);
            end else begin
                logic [8:0] e;
                e = q32.pop_front();
                if ({out_last32, out_data32} !== e) begin
                    n_fail++;
                    $display("FAIL sb32_byte: got byte %h last %b, required byte %h last %b",
                             out_data32, out_last32, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic send16(input logic [15:0] d, input logic nar);
        bit acc = 0;
        int n;
        in_valid16  = 1'b1;
        in_data16   = d;
        in_narrow16 = nar;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            if (in_ready16 && reset) begin
                acc = 1;
                n = nar ? 1 : 2;
                for (int i = 0; i < n; i++) q16.push_back({(i == n - 1), d[8*i +: 8]});
            end
            @(posedge clk); #1;
        end
        in_valid16 = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send16_timeout: word %h accepted=%0d, required 1", d, acc);
        end
    endtask

    task automatic send32(input logic [31:0] d, input logic nar);
        bit acc = 0;
        int n;
        in_valid32  = 1'b1;
        in_data32   = d;
        in_narrow32 = nar;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            if (in_ready32 && reset) begin
                acc = 1;
                n = nar ? 1 : 4;
                for (int i = 0; i < n; i++) q32.push_back({(i == n - 1), d[8*i +: 8]});
            end
            @(posedge clk); #1;
        end
        in_valid32 = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send32_timeout: word %h accepted=%0d, required 1", d, acc);
        end
    endtask

    task automatic drain16(input string name);
        int c = 0;
        while (c < 50 && (q16.size() != 0 || busy16)) begin
            @(posedge clk); #1;
            c++;
        end
        @(negedge clk);
        n_checks++;
        if (q16.size() != 0 || busy16 !== 1'b0 || out_valid16 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d busy=%b valid=%b, required 0 0 0",
                     name, q16.size(), busy16, out_valid16);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        in_valid16 = 1'b1; in_data16 = 16'h7777; in_narrow16 = 1'b0; out_ready16 = 1'b1;
        in_valid32 = 1'b0; in_data32 = '0; in_narrow32 = 1'b0; out_ready32 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid16 !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b, required 0 0", out_valid16, busy16);
        end
        n_checks++;
        if (out_data16 !== 8'h00 || out_last16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h last=%b, required 00 0", out_data16, out_last16);
        end
        n_checks++;
        if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: ready16=%b ready32=%b, required 1 1", in_ready16, in_ready32);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_word;
        send16(16'hA55A, 1'b0);
        @(negedge clk);
        n_checks++;
        if (in_ready16 !== 1'b0 || out_last16 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_first: ready=%b last=%b, required 0 0", in_ready16, out_last16);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready16 !== 1'b1 || out_data16 !== 8'hA5) begin
            n_fail++;
            $display("FAIL full_last_ready: ready=%b data=%h, required 1 a5", in_ready16, out_data16);
        end
        @(posedge clk); #1;
        drain16("full");
    endtask

    task automatic test_narrow;
        send16(16'h12FF, 1'b1);
        @(negedge clk);
        n_checks++;
        if (busy16 !== 1'b1 || out_last16 !== 1'b1 || out_data16 !== 8'hFF) begin
            n_fail++;
            $display("FAIL narrow_byte: busy=%b last=%b data=%h, required 1 1 ff",
                     busy16, out_last16, out_data16);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (busy16 !== 1'b0 || out_valid16 !== 1'b0) begin
            n_fail++;
            $display("FAIL narrow_oneshot: busy=%b valid=%b, required 0 0", busy16, out_valid16);
        end
        @(posedge clk); #1;
        drain16("narrow");
    endtask

    task automatic test_back_to_back;
        send16(16'h1122, 1'b0);
        fork
            send16(16'h3344, 1'b0);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid16 !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_gap: cycle %0d valid=%b, required 1", i, out_valid16);
                    end
                end
            end
        join
        drain16("b2b");
    endtask

    task automatic test_backpressure;
        out_ready16 = 1'b0;
        send16(16'hBEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid16 !== 1'b1 || out_data16 !== 8'hEF || out_last16 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%h last=%b, required 1 ef 0",
                         i, out_valid16, out_data16, out_last16);
            end
            @(posedge clk); #1;
            in_data16 = 16'($urandom);
            in_narrow16 = 1'($urandom);
        end
        out_ready16 = 1'b1;
        drain16("bp");
    endtask

    task automatic test_reset_midword;
        send16(16'hCAFE, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        q16.delete();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || out_data16 !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: valid=%b busy=%b data=%h, required 0 0 00",
                     out_valid16, busy16, out_data16);
        end
        @(posedge clk); #1;
        send16(16'h0102, 1'b0);
        drain16("midreset");
    endtask

    task automatic test_wide32;
        int c = 0;
        send32(32'hDEADBEEF, 1'b0);
        send32(32'hDEADBEEF, 1'b1);
        while (c < 50 && (q32.size() != 0 || busy32)) begin
            @(posedge clk); #1;
            c++;
        end
        @(negedge clk);
        n_checks++;
        if (q32.size() != 0 || busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide32_drain: pending=%0d busy=%b, required 0 0", q32.size(), busy32);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_narrow();
        test_back_to_back();
        test_backpressure();
        test_reset_midword();
        test_wide32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
